// File: rtl/fiber_pkg.sv
// Shared request-type encodings, legality check and arbiter state enum for the
// fiber cache bank front end.
package fiber_pkg;

   localparam logic [3:0] FETCH_REQ   = 4'b0001;
   localparam logic [3:0] READ_REQ    = 4'b0010;
   localparam logic [3:0] WRITE_REQ   = 4'b0100;
   localparam logic [3:0] CONSUME_REQ = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WDATA,
      ST_RESP
   } arb_state_e;

   function automatic logic is_legal_type(input logic [3:0] t);
      return (t == FETCH_REQ) || (t == READ_REQ) ||
             (t == WRITE_REQ) || (t == CONSUME_REQ);
   endfunction

endpackage

// File: rtl/fiber_bank_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int N   = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] grant_id,
   output logic           any
);

   logic [IDW:0] idx;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      any      = 1'b0;
      idx      = '0;
      for (int off = 0; off < N; off++) begin
         // Extra bit keeps ptr+off from overflowing before the modulo-N wrap.
         idx = {1'b0, ptr} + (IDW+1)'(off);
         if (idx >= (IDW+1)'(N))
            idx = idx - (IDW+1)'(N);
         if (!any && req[idx[IDW-1:0]]) begin
            any                   = 1'b1;
            grant[idx[IDW-1:0]]   = 1'b1;
            grant_id              = idx[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/fiber_bank_arbiter.sv
// Shares one fiber cache bank between NUM_PE ports: round-robin grant, registered
// request issue, then steering of one write beat or one read response.
module fiber_bank_arbiter
   import fiber_pkg::*;
#(
   parameter int NUM_PE     = 4,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 64,
   localparam int IDW       = $clog2(NUM_PE)
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic [4*NUM_PE-1:0]          i_pe_request_type,
   input  logic [ADDR_WIDTH*NUM_PE-1:0] i_pe_addr,
   input  logic [NUM_PE-1:0]            i_pe_type_valid,
   output logic [NUM_PE-1:0]            o_pe_type_ready,
   input  logic [DATA_WIDTH*NUM_PE-1:0] i_pe_data,
   input  logic [NUM_PE-1:0]            i_pe_data_valid,
   output logic [NUM_PE-1:0]            o_pe_data_ready,
   output logic [DATA_WIDTH-1:0]        o_pe_rdata,
   output logic [NUM_PE-1:0]            o_pe_rdata_valid,
   input  logic [NUM_PE-1:0]            i_pe_rdata_ready,
   output logic [3:0]                   o_bank_request_type,
   output logic [ADDR_WIDTH-1:0]        o_bank_addr,
   output logic                         o_bank_type_valid,
   input  logic                         i_bank_type_ready,
   output logic [DATA_WIDTH-1:0]        o_bank_data,
   output logic                         o_bank_data_valid,
   input  logic                         i_bank_data_ready,
   input  logic [DATA_WIDTH-1:0]        i_bank_rdata,
   input  logic                         i_bank_rdata_valid,
   output logic                         o_bank_rdata_ready,
   output logic [IDW-1:0]               o_grant_id,
   output logic                         o_busy,
   output logic                         o_illegal
);

   arb_state_e            state, state_nxt;
   logic [IDW-1:0]        rr_ptr;
   logic [IDW-1:0]        grant_id_q;
   logic [3:0]            type_q;
   logic [ADDR_WIDTH-1:0] addr_q;

   logic [NUM_PE-1:0]     arb_grant;
   logic [IDW-1:0]        arb_id;
   logic                  arb_any;
   logic                  accept;
   logic [3:0]            sel_type;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] g_wdata;
   logic                  g_wvalid;
   logic                  g_rready;

   rr_arbiter #(.N(NUM_PE)) u_rr (
      .req      (i_pe_type_valid),
      .ptr      (rr_ptr),
      .grant    (arb_grant),
      .grant_id (arb_id),
      .any      (arb_any)
   );

   // Payload of the PE winning arbitration, and channels of the PE holding the bank.
   always_comb begin
      sel_type = '0;
      sel_addr = '0;
      g_wdata  = '0;
      g_wvalid = 1'b0;
      g_rready = 1'b0;
      for (int p = 0; p < NUM_PE; p++) begin
         if (arb_grant[p]) begin
            sel_type = i_pe_request_type[4*p +: 4];
            sel_addr = i_pe_addr[ADDR_WIDTH*p +: ADDR_WIDTH];
         end
         if (p == int'(grant_id_q)) begin
            g_wdata  = i_pe_data[DATA_WIDTH*p +: DATA_WIDTH];
            g_wvalid = i_pe_data_valid[p];
            g_rready = i_pe_rdata_ready[p];
         end
      end
   end

   assign accept = (state == ST_IDLE) && arb_any;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= ST_IDLE;
         rr_ptr     <= '0;
         grant_id_q <= '0;
         type_q     <= '0;
         addr_q     <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            type_q     <= sel_type;
            addr_q     <= sel_addr;
            grant_id_q <= arb_id;
            rr_ptr     <= (arb_id == IDW'(NUM_PE-1)) ? '0 : arb_id + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt          = state;
      o_pe_type_ready    = '0;
      o_illegal          = 1'b0;
      o_bank_type_valid  = 1'b0;
      o_bank_data        = '0;
      o_bank_data_valid  = 1'b0;
      o_pe_data_ready    = '0;
      o_pe_rdata         = '0;
      o_pe_rdata_valid   = '0;
      o_bank_rdata_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            if (arb_any) begin
               o_pe_type_ready = arb_grant;
               if (is_legal_type(sel_type))
                  state_nxt = ST_ISSUE;
               else
                  o_illegal = 1'b1;
            end
         end
         ST_ISSUE: begin
            o_bank_type_valid = 1'b1;
            if (i_bank_type_ready) begin
               case (type_q)
                  WRITE_REQ: state_nxt = ST_WDATA;
                  READ_REQ:  state_nxt = ST_RESP;
                  default:   state_nxt = ST_IDLE;
               endcase
            end
         end
         ST_WDATA: begin
            o_bank_data                 = g_wdata;
            o_bank_data_valid           = g_wvalid;
            o_pe_data_ready[grant_id_q] = i_bank_data_ready;
            if (g_wvalid && i_bank_data_ready)
               state_nxt = ST_IDLE;
         end
         ST_RESP: begin
            o_pe_rdata                   = i_bank_rdata;
            o_pe_rdata_valid[grant_id_q] = i_bank_rdata_valid;
            o_bank_rdata_ready           = g_rready;
            if (i_bank_rdata_valid && g_rready)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign o_bank_request_type = type_q;
   assign o_bank_addr         = addr_q;
   assign o_grant_id          = grant_id_q;
   assign o_busy              = (state != ST_IDLE);

endmodule

// File: tb/tb_fiber_bank_arbiter.sv
// Bench for fiber_bank_arbiter: directed corner cases plus a randomized run
// scored against a queue-based round-robin reference model.
module tb_fiber_bank_arbiter;
   import fiber_pkg::*;

   localparam int NUM_PE  = 4;
   localparam int DW      = 16;
   localparam int AW      = 64;
   localparam int IDW     = 2;
   localparam int N_ITEMS = 8;

   logic                   i_clk = 1'b0;
   logic                   i_reset;
   logic [4*NUM_PE-1:0]    pe_type;
   logic [AW*NUM_PE-1:0]   pe_addr;
   logic [NUM_PE-1:0]      pe_type_valid;
   logic [NUM_PE-1:0]      o_pe_type_ready;
   logic [DW*NUM_PE-1:0]   pe_data;
   logic [NUM_PE-1:0]      pe_data_valid;
   logic [NUM_PE-1:0]      o_pe_data_ready;
   logic [DW-1:0]          o_pe_rdata;
   logic [NUM_PE-1:0]      o_pe_rdata_valid;
   logic [NUM_PE-1:0]      pe_rdata_ready;
   logic [3:0]             o_bank_request_type;
   logic [AW-1:0]          o_bank_addr;
   logic                   o_bank_type_valid;
   logic                   bank_type_ready;
   logic [DW-1:0]          o_bank_data;
   logic                   o_bank_data_valid;
   logic                   bank_data_ready;
   logic [DW-1:0]          bank_rdata;
   logic                   bank_rdata_valid;
   logic                   o_bank_rdata_ready;
   logic [IDW-1:0]         o_grant_id;
   logic                   o_busy;
   logic                   o_illegal;

   fiber_bank_arbiter #(.NUM_PE(NUM_PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .i_clk               (i_clk),
      .i_reset             (i_reset),
      .i_pe_request_type   (pe_type),
      .i_pe_addr           (pe_addr),
      .i_pe_type_valid     (pe_type_valid),
      .o_pe_type_ready     (o_pe_type_ready),
      .i_pe_data           (pe_data),
      .i_pe_data_valid     (pe_data_valid),
      .o_pe_data_ready     (o_pe_data_ready),
      .o_pe_rdata          (o_pe_rdata),
      .o_pe_rdata_valid    (o_pe_rdata_valid),
      .i_pe_rdata_ready    (pe_rdata_ready),
      .o_bank_request_type (o_bank_request_type),
      .o_bank_addr         (o_bank_addr),
      .o_bank_type_valid   (o_bank_type_valid),
      .i_bank_type_ready   (bank_type_ready),
      .o_bank_data         (o_bank_data),
      .o_bank_data_valid   (o_bank_data_valid),
      .i_bank_data_ready   (bank_data_ready),
      .i_bank_rdata        (bank_rdata),
      .i_bank_rdata_valid  (bank_rdata_valid),
      .o_bank_rdata_ready  (o_bank_rdata_ready),
      .o_grant_id          (o_grant_id),
      .o_busy              (o_busy),
      .o_illegal           (o_illegal)
   );

   always #5 i_clk = ~i_clk;

   typedef struct { logic [3:0] t; logic [AW-1:0] a; logic [DW-1:0] d; } item_t;
   typedef struct { int pe; logic ill; } grant_t;
   typedef struct { int pe; logic [3:0] t; logic [AW-1:0] a; } issue_t;
   typedef struct { int pe; logic [DW-1:0] d; } resp_t;

   item_t         items [NUM_PE][$];
   grant_t        grant_exp[$];
   issue_t        issue_exp[$];
   logic [DW-1:0] wr_exp[$];
   resp_t         rd_exp[$];

   int   n_vec = 0;
   int   n_err = 0;
   logic mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic one_hot4(input logic [3:0] t);
      return $countones(t) == 1;
   endfunction

   // Random transaction lists per PE; the expected event streams come from a
   // round-robin walk over the PEs that still have work queued.
   task automatic build_stimulus();
      int    mpos[NUM_PE];
      int    ptr, left, sel, r;
      item_t it;
      for (int p = 0; p < NUM_PE; p++) begin
         items[p].delete();
         mpos[p] = 0;
         for (int k = 0; k < N_ITEMS; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      it.t = FETCH_REQ;
            else if (r < 5) it.t = READ_REQ;
            else if (r < 8) it.t = WRITE_REQ;
            else if (r < 9) it.t = CONSUME_REQ;
            else begin
               it.t = 4'($urandom_range(0, 15));
               while (one_hot4(it.t)) it.t = 4'($urandom_range(0, 15));
            end
            it.a = {32'($urandom), 32'($urandom)};
            it.d = 16'($urandom);
            items[p].push_back(it);
         end
      end
      left = NUM_PE * N_ITEMS;
      ptr  = 0;
      while (left > 0) begin
         sel = -1;
         for (int off = 0; off < NUM_PE; off++)
            if (sel < 0 && mpos[(ptr+off)%NUM_PE] < items[(ptr+off)%NUM_PE].size())
               sel = (ptr + off) % NUM_PE;
         it = items[sel][mpos[sel]];
         mpos[sel]++;
         left--;
         ptr = (sel + 1) % NUM_PE;
         grant_exp.push_back('{sel, !one_hot4(it.t)});
         if (one_hot4(it.t)) begin
            issue_exp.push_back('{sel, it.t, it.a});
            if (it.t == WRITE_REQ) wr_exp.push_back(it.d);
            if (it.t == READ_REQ)  rd_exp.push_back('{sel, it.a[15:0] ^ 16'h5A5A});
         end
      end
   endtask

   function automatic int pending();
      return grant_exp.size() + issue_exp.size() + wr_exp.size() + rd_exp.size();
   endfunction

   grant_t mg;
   issue_t mi;
   resp_t  mr;
   logic [DW-1:0] mw;

   always @(negedge i_clk) begin
      if (mon_en) begin
         if (o_pe_type_ready != '0) begin
            if (grant_exp.size() == 0)
               check("grant_unexpected", 64'(o_pe_type_ready), 64'd0);
            else begin
               mg = grant_exp.pop_front();
               check("grant_pe", 64'(o_pe_type_ready), 64'(1) << mg.pe);
               check("grant_illegal", 64'(o_illegal), 64'(mg.ill));
            end
         end else if (o_illegal)
            check("illegal_spurious", 64'(o_illegal), 64'd0);
         if (o_bank_type_valid && bank_type_ready) begin
            if (issue_exp.size() == 0)
               check("issue_unexpected", 64'(o_bank_type_valid), 64'd0);
            else begin
               mi = issue_exp.pop_front();
               check("issue_type", 64'(o_bank_request_type), 64'(mi.t));
               check("issue_addr", o_bank_addr, mi.a);
               check("issue_grant_id", 64'(o_grant_id), 64'(mi.pe));
            end
         end
         if (o_bank_data_valid && bank_data_ready) begin
            if (wr_exp.size() == 0)
               check("wbeat_unexpected", 64'(o_bank_data_valid), 64'd0);
            else begin
               mw = wr_exp.pop_front();
               check("wbeat_data", 64'(o_bank_data), 64'(mw));
            end
         end
         if ((o_pe_rdata_valid & pe_rdata_ready) != '0) begin
            if (rd_exp.size() == 0)
               check("resp_unexpected", 64'(o_pe_rdata_valid), 64'd0);
            else begin
               mr = rd_exp.pop_front();
               check("resp_valid_vec", 64'(o_pe_rdata_valid), 64'(1) << mr.pe);
               check("resp_data", 64'(o_pe_rdata), 64'(mr.d));
            end
         end
      end
   end

   task automatic present(input int p, input int idx);
      if (idx < items[p].size()) begin
         pe_type_valid[p]     = 1'b1;
         pe_type[4*p +: 4]    = items[p][idx].t;
         pe_addr[AW*p +: AW]  = items[p][idx].a;
      end else
         pe_type_valid[p] = 1'b0;
   endtask

   task automatic run_random();
      int                pos[NUM_PE];
      logic              wpend[NUM_PE];
      logic [DW-1:0]     wdat[NUM_PE];
      logic [NUM_PE-1:0] tfire, dfire;
      logic              rfire, rd_issue, rd_pend;
      int                rd_cnt, cyc;
      logic [DW-1:0]     rd_val;
      rd_pend = 1'b0;
      rd_cnt  = 0;
      rd_val  = '0;
      mon_en  = 1'b1;
      for (int p = 0; p < NUM_PE; p++) begin
         pos[p]   = 0;
         wpend[p] = 1'b0;
         wdat[p]  = '0;
         present(p, 0);
      end
      cyc = 0;
      while (cyc < 20000 && pending() != 0) begin
         @(negedge i_clk);
         tfire    = pe_type_valid & o_pe_type_ready;
         dfire    = pe_data_valid & o_pe_data_ready;
         rfire    = bank_rdata_valid && o_bank_rdata_ready;
         rd_issue = o_bank_type_valid && bank_type_ready && (o_bank_request_type == READ_REQ);
         if (rd_issue) begin
            rd_pend = 1'b1;
            rd_cnt  = $urandom_range(0, 3);
            rd_val  = o_bank_addr[15:0] ^ 16'h5A5A;
         end
         tick();
         cyc++;
         for (int p = 0; p < NUM_PE; p++) begin
            if (tfire[p]) begin
               if (items[p][pos[p]].t == WRITE_REQ) begin
                  wpend[p] = 1'b1;
                  wdat[p]  = items[p][pos[p]].d;
               end
               pos[p]++;
               present(p, pos[p]);
            end
            if (dfire[p]) wpend[p] = 1'b0;
            pe_data[DW*p +: DW] = wpend[p] ? wdat[p] : 16'hDEAD;
            pe_data_valid[p]    = ($urandom_range(0, 3) != 0);
            pe_rdata_ready[p]   = ($urandom_range(0, 2) != 0);
         end
         bank_type_ready = ($urandom_range(0, 3) != 0);
         bank_data_ready = ($urandom_range(0, 2) != 0);
         if (rfire) begin
            rd_pend          = 1'b0;
            bank_rdata_valid = 1'b0;
         end else if (rd_pend) begin
            if (rd_cnt == 0) begin
               bank_rdata_valid = 1'b1;
               bank_rdata       = rd_val;
            end else
               rd_cnt--;
         end
      end
      check("drain_outstanding", 64'(pending()), 64'd0);
      mon_en = 1'b0;
   endtask

   task automatic clear_inputs();
      pe_type = '0; pe_addr = '0; pe_type_valid = '0;
      pe_data = '0; pe_data_valid = '0; pe_rdata_ready = '0;
      bank_type_ready = 1'b0; bank_data_ready = 1'b0;
      bank_rdata = '0; bank_rdata_valid = 1'b0;
   endtask

   initial begin
      i_reset = 1'b1;
      clear_inputs();
      tick(); tick(); tick();
      @(negedge i_clk);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_bank_valid", 64'(o_bank_type_valid), 64'd0);
      check("rst_bank_type", 64'(o_bank_request_type), 64'd0);
      check("rst_bank_addr", o_bank_addr, 64'd0);
      check("rst_grant_id", 64'(o_grant_id), 64'd0);
      check("rst_illegal", 64'(o_illegal), 64'd0);
      check("rst_type_ready", 64'(o_pe_type_ready), 64'd0);
      check("rst_rdata_ready", 64'(o_bank_rdata_ready), 64'd0);

      // Stray bank response while idle must not be acked or forwarded.
      tick();
      i_reset = 1'b0;
      bank_rdata_valid = 1'b1; bank_rdata = 16'h7777; pe_rdata_ready = '1;
      @(negedge i_clk);
      check("stray_rdata_ready", 64'(o_bank_rdata_ready), 64'd0);
      check("stray_rdata_valid", 64'(o_pe_rdata_valid), 64'd0);
      tick();
      clear_inputs();

      // Illegal type from PE0 with PE1 waiting.
      bank_type_ready = 1'b1;
      pe_type_valid = 4'b0011;
      pe_type[3:0] = 4'b0011; pe_type[7:4] = FETCH_REQ;
      pe_addr[AW +: AW] = 64'h2000;
      @(negedge i_clk);
      check("ill_grant", 64'(o_pe_type_ready), 64'h1);
      check("ill_pulse", 64'(o_illegal), 64'd1);
      check("ill_no_issue", 64'(o_bank_type_valid), 64'd0);
      tick();
      pe_type_valid[0] = 1'b0;
      @(negedge i_clk);
      check("ill_pulse_end", 64'(o_illegal), 64'd0);
      check("ill_next_grant", 64'(o_pe_type_ready), 64'h2);
      check("ill_still_idle", 64'(o_busy), 64'd0);
      tick();
      pe_type_valid[1] = 1'b0;
      @(negedge i_clk);
      check("pe1_issue_valid", 64'(o_bank_type_valid), 64'd1);
      check("pe1_issue_addr", o_bank_addr, 64'h2000);

      // Single FETCH from PE2.
      tick();
      pe_type_valid[2] = 1'b1; pe_type[11:8] = FETCH_REQ; pe_addr[2*AW +: AW] = 64'h1000;
      @(negedge i_clk);
      check("fetch_grant", 64'(o_pe_type_ready), 64'h4);
      tick();
      pe_type_valid[2] = 1'b0;
      @(negedge i_clk);
      check("fetch_valid", 64'(o_bank_type_valid), 64'd1);
      check("fetch_type", 64'(o_bank_request_type), 64'(FETCH_REQ));
      check("fetch_addr", o_bank_addr, 64'h1000);
      tick();
      @(negedge i_clk);
      check("fetch_busy_low", 64'(o_busy), 64'd0);
      check("fetch_grant_id", 64'(o_grant_id), 64'd2);

      tick();
      clear_inputs();
      i_reset = 1'b1;
      tick(); tick();
      i_reset = 1'b0;
      build_stimulus();
      run_random();
      tick();
      clear_inputs();
      tick(); tick();

      // READ from PE1, then reset while its response is pending.
      bank_type_ready = 1'b1;
      pe_type_valid = 4'b0010; pe_type[7:4] = READ_REQ; pe_addr[AW +: AW] = 64'h3000;
      @(negedge i_clk);
      check("rd_grant", 64'(o_pe_type_ready), 64'h2);
      tick();
      pe_type_valid = '0;
      tick();
      bank_rdata_valid = 1'b1; bank_rdata = 16'h1234;
      @(negedge i_clk);
      check("resp_steer_vec", 64'(o_pe_rdata_valid), 64'h2);
      check("resp_steer_data", 64'(o_pe_rdata), 64'h1234);
      tick();
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      pe_rdata_ready = '1;
      @(negedge i_clk);
      check("midrst_busy", 64'(o_busy), 64'd0);
      check("midrst_rdata_ready", 64'(o_bank_rdata_ready), 64'd0);
      check("midrst_rdata_valid", 64'(o_pe_rdata_valid), 64'd0);
      check("midrst_grant_id", 64'(o_grant_id), 64'd0);
      check("midrst_bank_addr", o_bank_addr, 64'd0);
      tick();
      bank_rdata_valid = 1'b0;
      pe_type_valid = 4'b1001; pe_type[3:0] = FETCH_REQ; pe_type[15:12] = FETCH_REQ;
      @(negedge i_clk);
      check("post_rst_grant", 64'(o_pe_type_ready), 64'h1);
      tick();
      clear_inputs();
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fiber_bank_arbiter.md
# fiber_bank_arbiter

Request arbiter and sequencer that shares one fiber cache bank between `NUM_PE` processing-element ports on the PE crossbar. It grants one PE at a time, round-robin, and registers that PE's request onto the bank's request-type channel. For the duration of the transaction it steers the write-data and read-response channels between the granted PE and the bank. It holds exactly one outstanding transaction and sits between the crossbar inputs and a single bank instance.

## Interface
- `NUM_PE`, default 4: number of requesting PE ports; 2..16.
- `DATA_WIDTH`, default 16: cache line / data beat width in bits.
- `ADDR_WIDTH`, default 64: request address width in bits.
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_reset`  in  1  reset, synchronous, active-high.
- `i_pe_request_type`  in  4*NUM_PE  per-PE one-hot request type; PE p uses bits [4p+3:4p].
- `i_pe_addr`  in  ADDR_WIDTH*NUM_PE  per-PE request address.
- `i_pe_type_valid` / `o_pe_type_ready`  in/out  NUM_PE  per-PE request handshake.
- `i_pe_data`  in  DATA_WIDTH*NUM_PE  per-PE write data.
- `i_pe_data_valid` / `o_pe_data_ready`  in/out  NUM_PE  per-PE write-data handshake.
- `o_pe_rdata`  out  DATA_WIDTH  read response data, broadcast to all PEs.
- `o_pe_rdata_valid` / `i_pe_rdata_ready`  out/in  NUM_PE  per-PE response handshake.
- `o_bank_request_type`, `o_bank_addr`  out  4, ADDR_WIDTH  registered request payload.
- `o_bank_type_valid` / `i_bank_type_ready`  out/in  1  bank request handshake.
- `o_bank_data`, `o_bank_data_valid` / `i_bank_data_ready`  out, out/in  DATA_WIDTH, 1, 1  bank write-data channel.
- `i_bank_rdata`, `i_bank_rdata_valid` / `o_bank_rdata_ready`  in, in/out  DATA_WIDTH, 1, 1  bank response channel.
- `o_grant_id`  out  clog2(NUM_PE)  index of the current or last granted PE.
- `o_busy`  out  1  high when the FSM state is not IDLE.
- `o_illegal`  out  1  one-cycle pulse when a request with an illegal type is dropped.

## Operation
- **Request types:** FETCH=0001, READ=0010, WRITE=0100, CONSUME=1000. Any other encoding, including 0000, is illegal.
- **FSM states:** IDLE, ISSUE, WDATA, RESP.
- **IDLE, arbitration:**
  - The request vector is `i_pe_type_valid`.
  - The grant goes to the first set bit at or above `rr_ptr`, wrapping around.
  - The granted PE sees `o_pe_type_ready[g]`=1 for that single cycle, and its type and address are captured into registers. No other PE sees ready.
  - `rr_ptr` is then set to (g+1) mod NUM_PE.
  - If the captured type is illegal: `o_illegal` pulses, the FSM stays in IDLE, and nothing is issued to the bank.
  - If the type is legal, the FSM goes to ISSUE.
- **ISSUE:**
  - `o_bank_type_valid`=1 with the registered payload, held stable until `i_bank_type_ready`.
  - On the handshake: WRITE goes to WDATA, READ goes to RESP, FETCH and CONSUME go to IDLE.
- **WDATA:**
  - `o_bank_data`=`i_pe_data[g]`.
  - `o_bank_data_valid`=`i_pe_data_valid[g]`.
  - `o_pe_data_ready[g]`=`i_bank_data_ready`.
  - One beat is transferred, then the FSM goes to IDLE. All other `o_pe_data_ready` bits are 0.
- **RESP:**
  - `o_pe_rdata`=`i_bank_rdata`.
  - `o_pe_rdata_valid[g]`=`i_bank_rdata_valid`.
  - `o_bank_rdata_ready`=`i_pe_rdata_ready[g]`.
  - One beat is transferred, then the FSM goes to IDLE.
- **Outside WDATA/RESP:** all steering outputs are 0, so stray bank responses are never acked.
- **Reset values:** all valid and ready outputs 0; `o_bank_request_type`=0; `o_bank_addr`=0; `o_grant_id`=0; `o_busy`=0; `o_illegal`=0; `rr_ptr`=0; state IDLE.

## Timing
- **Request accept to bank issue:** a request accepted in cycle T drives `o_bank_type_valid` from T+1.
- **Minimum occupancy:**
  - FETCH/CONSUME: 2 cycles.
  - WRITE: 3 cycles when all readies are high.
  - READ: 3 cycles plus bank latency.
- **Back-to-back:** the next grant happens at the earliest in the cycle after the completing handshake. The FSM returns to IDLE and arbitrates in that same IDLE cycle, with no extra bubble.
- **Fairness:** under continuous requests from all PEs, grants rotate 0,1,…,NUM_PE-1,0. Each PE is granted at most once per NUM_PE grants.
- **Withdrawn requests:** a PE that drops `i_pe_type_valid` before it is granted is simply not considered; there is no sticky request state.
- **Reset mid-transaction:** the transaction is abandoned. All outputs are at reset values in the cycle after `i_reset` is sampled high. The bank is not notified; the system is responsible for resetting the bank alongside.
- **Simultaneous events:** the grant and the illegal-type drop occur in the same IDLE cycle. `rr_ptr` still advances past an illegal requester.

## Structure
- **Shared package `fiber_pkg`:**
  - request-type constants FETCH_REQ, READ_REQ, WRITE_REQ, CONSUME_REQ;
  - an `is_legal_type` function (one-hot check);
  - the arbiter state enum.
- **Sub-module `rr_arbiter`:**
  - parameter `N`;
  - inputs `req[N]` and `ptr`;
  - outputs one-hot `grant[N]`, `grant_id`, `any`.
  - It is purely combinational. The pointer register lives in `fiber_bank_arbiter`.

## Test plan
- **Reset then single FETCH:** PE2 requests FETCH at 0x1000 with the bank ready -> `o_pe_type_ready[2]` at T, `o_bank_type_valid` at T+1 with type 0001 and addr 0x1000, `o_busy` low at T+2, `o_grant_id`=2.
- **All four PEs request READ continuously, bank responds 1 cycle after issue with data 0xA0+p** -> grant order 0,1,2,3,0, and each PE receives its own data only on its own `o_pe_rdata_valid` bit.
- **WRITE from PE1 with `i_bank_data_ready` held low 3 cycles, data 0xBEEF** -> `o_bank_data`=0xBEEF, held valid; `o_pe_data_ready[1]` stays low until the bank is ready; FSM returns to IDLE after the beat.
- **PE0 issues type 0011** -> `o_illegal` pulses for 1 cycle, no `o_bank_type_valid`, `rr_ptr` becomes 1, and a pending PE1 is granted the next cycle.
- **`i_reset` asserted during RESP with a bank response pending** -> all outputs at reset values the next cycle, `o_bank_rdata_ready`=0, and the next grant goes to PE0.
- **Stray `i_bank_rdata_valid` in IDLE** -> `o_bank_rdata_ready`=0 and all `o_pe_rdata_valid` bits are 0.
